szg_i2s2_pmod_tx: RTL and testbench

SZG_I2S2_PMOD_TX -- requirements
Module: szg_i2s2_pmod_tx

---
 rtl/szg_i2s2_pkg.sv | 30 +++
 rtl/szg_i2s2_clkgen.sv | 48 ++++
 rtl/szg_i2s2_pmod_tx.sv | 118 +++++++++++
 tb/tb_szg_i2s2_pmod_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/szg_i2s2_pkg.sv
// Shared constants for the SZG I2S2 Pmod PHYs (transmit and receive).
// Frame timing: one frame = 512 clk = 64 slots of 8 clk; slot k = cnt[8:3],
// k[5] selects the channel (0 left, 1 right), k[4:0] is the bit position.
package szg_i2s2_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SLOT_W   = 32;
  localparam int unsigned CNT_W    = 9;

  // Divider taps on the free-running counter
  localparam int unsigned MCLK_BIT = 0;  // clk/2   = 256 Fs
  localparam int unsigned SCLK_BIT = 2;  // clk/8   =  64 Fs
  localparam int unsigned LRCK_BIT = 8;  // clk/512 =   1 Fs
  localparam int unsigned SLOT_LSB = 3;  // cnt[CNT_W-1:SLOT_LSB] is the slot index

  // Holding-register state encoding
  localparam logic [0:0] HOLD_EMPTY = 1'b0;
  localparam logic [0:0] HOLD_FULL  = 1'b1;

  // I2S bit for position p within a 32-bit slot group: MSB at p=1, LSB at
  // p=24, zero at p=0 (one-bit delay after lrck edge) and the 8 pad bits.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                    input logic [4:0]          p);
    logic [4:0] idx;
    idx = 5'(SAMPLE_W) - p;
    if (p >= 5'd1 && p <= 5'(SAMPLE_W)) return word[idx];
    return 1'b0;
  endfunction

endpackage

// File: rtl/szg_i2s2_clkgen.sv
// Frame counter and DAC clock generator.
//   clk, reset_n      : system clock (512 Fs), async active-low reset
//   cnt_next          : counter value that cnt takes on the next clk edge
//   tx_mclk/sclk/lrck : registered divider outputs, glitch-free
module szg_i2s2_clkgen
  import szg_i2s2_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] cnt_next,
  output logic             tx_mclk,
  output logic             tx_sclk,
  output logic             tx_lrck
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mclk_q, mclk_d;
  logic sclk_q, sclk_d;
  logic lrck_q, lrck_d;

  // Clock flops take the next counter value so they stay aligned with cnt_q.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    mclk_d = cnt_d[MCLK_BIT];
    sclk_d = cnt_d[SCLK_BIT];
    lrck_d = cnt_d[LRCK_BIT];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= mclk_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
    end
  end

  assign cnt_next = cnt_d;
  assign tx_mclk  = mclk_q;
  assign tx_sclk  = sclk_q;
  assign tx_lrck  = lrck_q;

endmodule

// File: rtl/szg_i2s2_pmod_tx.sv
// I2S transmit PHY for the SZG I2S2 Pmod DAC.
//   clk, reset_n          : 512 Fs system clock, async active-low reset
//   s_valid/s_ready       : stereo sample handshake (one-deep holding register)
//   l_data, r_data        : 24-bit two's-complement samples, sent verbatim
//   mute                  : sampled at frame load, forces an all-zero frame
//   tx_mclk/lrck/sclk/sdout : DAC pins
//   underrun              : one-clk pulse when a frame loads with nothing held
module szg_i2s2_pmod_tx
  import szg_i2s2_pkg::*;
#(
  parameter int unsigned MUTE_ON_UNDERRUN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] l_data,
  input  logic [SAMPLE_W-1:0] r_data,
  input  logic                mute,
  output logic                tx_mclk,
  output logic                tx_lrck,
  output logic                tx_sclk,
  output logic                tx_sdout,
  output logic                underrun
);

  logic [CNT_W-1:0] cnt_next;

  szg_i2s2_clkgen u_clkgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .cnt_next (cnt_next),
    .tx_mclk  (tx_mclk),
    .tx_sclk  (tx_sclk),
    .tx_lrck  (tx_lrck)
  );

  logic [0:0]          hold_state_q, hold_state_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic                sdout_q, sdout_d;
  logic                underrun_q, underrun_d;

  logic                       frame_load, sclk_fall, accept;
  logic [CNT_W-SLOT_LSB-1:0]  slot;

  assign frame_load = (cnt_next == '0);
  assign sclk_fall  = (cnt_next[SLOT_LSB-1:0] == '0);
  assign slot       = cnt_next[CNT_W-1:SLOT_LSB];
  assign s_ready    = (hold_state_q == HOLD_EMPTY);
  assign accept     = s_valid && s_ready;

  always_comb begin
    hold_state_d = hold_state_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    frame_l_d    = frame_l_q;
    frame_r_d    = frame_r_q;
    sdout_d      = sdout_q;
    underrun_d   = 1'b0;

    if (frame_load) begin
      if (hold_state_q == HOLD_FULL) begin
        frame_l_d    = hold_l_q;
        frame_r_d    = hold_r_q;
        hold_state_d = HOLD_EMPTY;
      end else begin
        underrun_d = 1'b1;
        if (MUTE_ON_UNDERRUN != 0) begin
          frame_l_d = '0;
          frame_r_d = '0;
        end
      end
      if (mute) begin
        frame_l_d = '0;
        frame_r_d = '0;
      end
    end

    // s_ready is low while FULL, so an accept never collides with a drain.
    if (accept) begin
      hold_l_d     = l_data;
      hold_r_d     = r_data;
      hold_state_d = HOLD_FULL;
    end

    // Slot 0 always carries a zero bit, so the frame registers reloading on
    // the same edge never affect the bit launched there.
    if (sclk_fall) begin
      sdout_d = slot_bit(slot[CNT_W-SLOT_LSB-1] ? frame_r_q : frame_l_q,
                         slot[4:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_state_q <= HOLD_EMPTY;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      frame_l_q    <= '0;
      frame_r_q    <= '0;
      sdout_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_state_q <= hold_state_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      frame_l_q    <= frame_l_d;
      frame_r_q    <= frame_r_d;
      sdout_q      <= sdout_d;
      underrun_q   <= underrun_d;
    end
  end

  assign tx_sdout = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_szg_i2s2_pmod_tx.sv
// Scoreboard bench: a frame-level reference model predicts the pin state after
// every clk edge for two instances (mute-on-underrun and repeat-on-underrun);
// a monitor on the falling edge pops the predictions and compares.
module tb_szg_i2s2_pmod_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        mute = 1'b0;
  logic [23:0] l_data = '0;
  logic [23:0] r_data = '0;

  logic a_ready, a_mclk, a_lrck, a_sclk, a_sdout, a_und;
  logic b_ready, b_mclk, b_lrck, b_sclk, b_sdout, b_und;

  szg_i2s2_pmod_tx #(.MUTE_ON_UNDERRUN(1)) dut_mute (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(a_ready),
    .l_data(l_data), .r_data(r_data), .mute(mute),
    .tx_mclk(a_mclk), .tx_lrck(a_lrck), .tx_sclk(a_sclk),
    .tx_sdout(a_sdout), .underrun(a_und)
  );

  szg_i2s2_pmod_tx #(.MUTE_ON_UNDERRUN(0)) dut_rep (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(b_ready),
    .l_data(l_data), .r_data(r_data), .mute(mute),
    .tx_mclk(b_mclk), .tx_lrck(b_lrck), .tx_sclk(b_sclk),
    .tx_sdout(b_sdout), .underrun(b_und)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n = 0;          // clk edges since reset release
  int          acc_cnt = 0;    // samples accepted so far
  logic [47:0] pend[$];        // pending frame (at most one)
  logic [23:0] m_l = '0, m_r = '0;   // frame on air, mute-on-underrun DUT
  logic [23:0] p_l = '0, p_r = '0;   // frame on air, repeat-on-underrun DUT
  // {mclk, sclk, lrck, sdout_mute, sdout_rep, underrun, s_ready}
  logic [6:0]  expq[$];

  function automatic logic i2s_bit(input logic [23:0] w, input int p);
    if (p >= 1 && p <= 24) return w[24-p];
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int   ph, k;
    logic was_empty, und;
    logic [6:0] e;
    logic [47:0] fr;
    if (!reset_n) begin
      n = 0;
      pend.delete();
      m_l = '0; m_r = '0; p_l = '0; p_r = '0;
      expq.push_back(7'b0000001);
    end else begin
      n++;
      ph = n % 512;
      was_empty = (pend.size() == 0);
      und = 1'b0;
      if (ph == 0) begin
        if (!was_empty) begin
          fr = pend.pop_front();
          m_l = fr[47:24]; m_r = fr[23:0];
          p_l = fr[47:24]; p_r = fr[23:0];
        end else begin
          und = 1'b1;
          m_l = '0; m_r = '0;
        end
        if (mute) begin
          m_l = '0; m_r = '0; p_l = '0; p_r = '0;
        end
      end
      if (s_valid && was_empty) begin
        pend.push_back({l_data, r_data});
        acc_cnt++;
      end
      k = ph / 8;
      e[6] = ph[0];
      e[5] = ph[2];
      e[4] = ph[8];
      e[3] = i2s_bit((k < 32) ? m_l : m_r, k % 32);
      e[2] = i2s_bit((k < 32) ? p_l : p_r, k % 32);
      e[1] = und;
      e[0] = (pend.size() == 0);
      expq.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    logic [6:0] e;
    logic [5:0] got, want;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got  = {a_mclk, a_sclk, a_lrck, a_sdout, a_und, a_ready};
      want = {e[6:4], e[3], e[1], e[0]};
      checks++;
      if (got !== want) begin
        errors++;
        if (errors <= 30)
          $display("FAIL pins_mute n=%0d got %b want %b (mclk sclk lrck sdout und rdy)", n, got, want);
      end
      got  = {b_mclk, b_sclk, b_lrck, b_sdout, b_und, b_ready};
      want = {e[6:4], e[2], e[1], e[0]};
      checks++;
      if (got !== want) begin
        errors++;
        if (errors <= 30)
          $display("FAIL pins_repeat n=%0d got %b want %b (mclk sclk lrck sdout und rdy)", n, got, want);
      end
    end
  end

  // All drives happen 1 time unit after a falling edge.
  task automatic tick(input int c);
    repeat (c) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    int a0;
    a0 = acc_cnt;
    l_data = l; r_data = r; s_valid = 1'b1;
    for (int i = 0; i < 1100 && acc_cnt == a0; i++) tick(1);
    if (acc_cnt == a0) begin
      checks++; errors++;
      $display("FAIL send_timeout got no accept want accept of %h/%h", l, r);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int i;
    for (i = 0; i < 600 && (n % 512) != ph; i++) tick(1);
    if ((n % 512) != ph) begin
      checks++; errors++;
      $display("FAIL wait_phase got %0d want %0d", n % 512, ph);
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tick(3);
    reset_n = 1'b1;
    // Starved: zero frames, periodic underrun
    tick(1100);
    // Directed patterns
    send(24'hA5A5A5, 24'h5A5A5A);
    tick(1100);
    send(24'h800001, 24'h800001);
    tick(1200);
    // Random offers with occasional mute
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      l_data  = 24'($urandom);
      r_data  = 24'($urandom);
      mute    = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    s_valid = 1'b0; mute = 1'b0;
    tick(1100);
    // Mute asserted mid-frame while a further sample is held
    wait_phase(5);
    send(24'h7FFFFF, 24'h7FFFFF);
    wait_phase(1);
    send(24'h123456, 24'h654321);
    wait_phase(100);
    mute = 1'b1;
    tick(1100);
    mute = 1'b0;
    // Reset mid-frame with the holding register full
    wait_phase(5);
    send(24'hABCDEF, 24'hFEDCBA);
    wait_phase(300);
    reset_n = 1'b0;
    tick(4);
    reset_n = 1'b1;
    tick(1100);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
